bn128_fp2_pnt_scl_unpack: RTL
=============================

# bn128_fp2_pnt_scl_unpack

Receive side of the packed G2 scalar/point stream used in front of the G2 multiexp core. The block consumes 256-bit, 7-beat frames of the form scalar, x0, x1, y0, y1, z0, z1, where (z0, z1) must equal (CONST_1, 0). It splits each frame into a 256-bit scalar stream and a 512-bit affine Fp2 point stream (2 beats per point), validates framing and the Z coordinate, and counts frames per job. It sits between a packed-stream transport (DMA, loopback or capture path) and consumers that expect the separate scl/pnt interfaces.

## Interface
Parameters:
- CHECK_Z, 1, when 1 a Z mismatch raises o_err; when 0 z0/z1 are consumed unchecked.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_num_in  in  64  frames per job; 0 means unbounded, so o_done never fires.
- i_pnt_scl_if  sink  if_axi_stream, DAT 256, CTL 1  packed frames. sop on the scalar beat, eop on the z1 beat.
- o_scl_if  source  if_axi_stream, DAT 256  one beat per frame, sop=eop=1.
- o_pnt_if  source  if_axi_stream, DAT 512  two beats per frame:
  - x = {x1, x0}, with sop.
  - y = {y1, y0}, with eop.
  - The fe at [0 +: 256] is the low (c0) element.
- o_err  out  1  single-cycle pulse per framing or Z error.
- o_frm_cnt  out  64  frames completed in the current job.
- o_done  out  1  single-cycle pulse when o_frm_cnt reaches i_num_in.

## Operation
- Beat counter `beat` runs 0..6, one state per frame beat: SCL, X0, X1, Y0, Y1, Z0, Z1. It advances only on an input handshake (val && rdy).
- SCL: the beat is copied to the o_scl_if output register (val=1, sop=eop=1).
- X0/Y0: the beat is latched into a 256-bit `lo` staging register. No output is produced.
- X1/Y1: {i.dat, lo} is loaded into the o_pnt_if output register.
  - sop=1 on the X1 load.
  - eop=1 on the Y1 load.
- Z0: if CHECK_Z and dat != CONST_1, pulse o_err.
- Z1: if CHECK_Z and dat != 0, pulse o_err. The frame completes:
  - o_frm_cnt increments.
  - If i_num_in != 0 and the new count == i_num_in: pulse o_done and clear o_frm_cnt to 0.
- Input ready:
  - If i.val && i.sop: rdy = scl_free.
  - Otherwise by beat:
    - SCL: scl_free.
    - X1, Y1: pnt_free.
    - X0, Y0, Z0, Z1: 1.
  - scl_free = ~o_scl_if.val || o_scl_if.rdy; pnt_free likewise for o_pnt_if.
- Output registers:
  - val clears on rdy unless a new load occurs in the same cycle.
  - dat and ctl hold while val && ~rdy.
- The scl and pnt outputs are independent. The scalar of frame n+1 may leave before point n completes; downstream joins them.

Framing errors (each pulses o_err for one cycle):
- sop accepted while beat != 0: the partial frame is abandoned and this beat is treated as SCL of a new frame, so beat becomes 1. Point beats already emitted are not retracted.
- Beat accepted at SCL without sop: the beat is dropped and beat stays 0.
- eop accepted while beat != 6: the beat is consumed and beat returns to 0. The frame is not counted.
- Z1 accepted without eop: counted as a completed frame anyway.
- Errors on the same beat produce a single pulse.

## Timing
- Latency: 1 cycle from input handshake to output val.
- Sustained throughput: 1 beat/cycle when both outputs are ready.
- An output stalled with rdy=0 blocks only the input beats that load it (SCL, X1, Y1).
- Reset values:
  - All val/sop/eop = 0 and dat = 0.
  - beat = 0, lo = 0.
  - o_err = 0, o_done = 0, o_frm_cnt = 0.
  - i_pnt_scl_if.rdy follows the combinational rule above from reset state.
- Reset mid-frame discards the partial frame and any held outputs with no pulses.
- Output rdy and a new load in the same cycle: the new beat is accepted and val stays 1 (back-to-back).
- o_done and o_err may pulse in the same cycle.
- o_frm_cnt is 64-bit wrapping; with i_num_in=0 it counts until 2^64 and wraps to 0.

## Structure
- bn128_pkg: fe_t, fe2_t, CONST_1 (existing).
- Add localparam FP2_PNT_SCL_BEATS = 7 to bn128_pkg; it is shared with the packing side.
- Single module with no sub-module. The two output registers are small enough to inline.

## Test plan
- Three well-formed frames, i_num_in=3, all outputs always ready:
  - Input: scl=5; x=(1,2); y=(3,4).
  - Expected: o_scl dat=5; o_pnt {2,1} sop, then {4,3} eop.
  - After the third frame: o_done pulses once, o_frm_cnt returns to 0, o_err never fires.
- Back-pressure: o_pnt_if.rdy=0 for 10 cycles during frame 1.
  - Input stalls only at beat X1.
  - The scalar of frame 1 is still emitted.
  - Data order is preserved with no duplicated or lost beats.
- Z error, CHECK_Z=1, z0=7: o_err pulses once on the Z0 handshake and the frame still counts. The same frame with CHECK_Z=0 gives no pulse.
- sop injected at beat 3:
  - o_err pulses and that beat appears on o_scl_if.
  - The next 6 beats form a complete frame and o_frm_cnt increments by 1.
- eop at beat 4: o_err pulses, beat returns to 0, and a following frame without sop at beat 0 is dropped with another o_err.
- i_rst asserted mid-frame at beat 2 with o_pnt val held: all outputs return to reset values next cycle, and a fresh frame then decodes correctly.

Source files
------------

// File: rtl/bn128_pkg.sv
// BN128 field element types and constants shared by the G2 stream blocks.
// Also holds the packed G2 scalar/point frame layout.
package bn128_pkg;

    typedef logic [255:0] fe_t;
    typedef fe_t [1:0] fe2_t;

    localparam fe_t CONST_1 = 256'd1;

    // Shared with the packing side: scalar, x0, x1, y0, y1, z0, z1
    localparam int FP2_PNT_SCL_BEATS = 7;

    typedef enum logic [2:0] {
        BT_SCL = 3'd0,
        BT_X0  = 3'd1,
        BT_X1  = 3'd2,
        BT_Y0  = 3'd3,
        BT_Y1  = 3'd4,
        BT_Z0  = 3'd5,
        BT_Z1  = 3'd6
    } fp2_pnt_scl_beat_t;

endpackage

// File: rtl/if_axi_stream.sv
// Simple valid/ready stream with start/end-of-packet markers.
interface if_axi_stream #(
    parameter int DAT_BITS = 256,
    parameter int CTL_BITS = 1
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport sink   (input val, sop, eop, dat, ctl, output rdy);
    modport source (output val, sop, eop, dat, ctl, input rdy);
endinterface

// File: rtl/bn128_fp2_pnt_scl_unpack.sv
// Splits packed 7-beat G2 frames into a scalar stream and an affine Fp2
// point stream, checking framing and Z, and counting frames per job.
module bn128_fp2_pnt_scl_unpack
    import bn128_pkg::*;
#(
    parameter bit CHECK_Z = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_num_in,
    if_axi_stream.sink   i_pnt_scl_if,
    if_axi_stream.source o_scl_if,
    if_axi_stream.source o_pnt_if,
    output logic        o_err,
    output logic [63:0] o_frm_cnt,
    output logic        o_done
);

    localparam fp2_pnt_scl_beat_t BT_LAST =
        fp2_pnt_scl_beat_t'(3'(FP2_PNT_SCL_BEATS - 1));

    fp2_pnt_scl_beat_t beat_q, beat_d;
    fe_t   lo_q, lo_d;
    logic  scl_val_q, scl_val_d;
    fe_t   scl_dat_q, scl_dat_d;
    logic  pnt_val_q, pnt_val_d;
    logic  pnt_sop_q, pnt_sop_d;
    logic  pnt_eop_q, pnt_eop_d;
    fe2_t  pnt_dat_q, pnt_dat_d;
    logic  err_q, err_d;
    logic  done_q, done_d;
    logic [63:0] frm_cnt_q, frm_cnt_d;

    logic scl_free, pnt_free, in_rdy, hs;
    logic scl_ld, pnt_ld, pnt_ld_sop;
    logic [63:0] cnt_inc;
    logic unused_ctl;

    assign unused_ctl = ^i_pnt_scl_if.ctl;

    always_comb begin
        scl_free = ~scl_val_q | o_scl_if.rdy;
        pnt_free = ~pnt_val_q | o_pnt_if.rdy;
        in_rdy   = 1'b1;
        if (i_pnt_scl_if.val && i_pnt_scl_if.sop) begin
            in_rdy = scl_free;
        end else begin
            case (beat_q)
                BT_SCL:       in_rdy = scl_free;
                BT_X1, BT_Y1: in_rdy = pnt_free;
                default:      in_rdy = 1'b1;
            endcase
        end
    end

    assign i_pnt_scl_if.rdy = in_rdy;
    assign hs = i_pnt_scl_if.val & in_rdy;
    assign cnt_inc = frm_cnt_q + 64'd1;

    always_comb begin
        beat_d     = beat_q;
        lo_d       = lo_q;
        scl_ld     = 1'b0;
        pnt_ld     = 1'b0;
        pnt_ld_sop = 1'b0;
        err_d      = 1'b0;
        done_d     = 1'b0;
        frm_cnt_d  = frm_cnt_q;
        if (hs) begin
            if (i_pnt_scl_if.sop) begin
                // A stray sop restarts framing on this beat
                err_d  = (beat_q != BT_SCL);
                scl_ld = 1'b1;
                beat_d = BT_X0;
            end else if (beat_q == BT_SCL) begin
                err_d = 1'b1;
            end else if (i_pnt_scl_if.eop && beat_q != BT_LAST) begin
                err_d  = 1'b1;
                beat_d = BT_SCL;
            end else begin
                beat_d = fp2_pnt_scl_beat_t'(beat_q + 3'd1);
                case (beat_q)
                    BT_X0, BT_Y0: lo_d = i_pnt_scl_if.dat;
                    BT_X1: begin
                        pnt_ld     = 1'b1;
                        pnt_ld_sop = 1'b1;
                    end
                    BT_Y1: pnt_ld = 1'b1;
                    BT_Z0: err_d = CHECK_Z && (i_pnt_scl_if.dat != CONST_1);
                    BT_Z1: begin
                        err_d  = (CHECK_Z && (i_pnt_scl_if.dat != '0))
                               || !i_pnt_scl_if.eop;
                        beat_d = BT_SCL;
                        if (i_num_in != '0 && cnt_inc == i_num_in) begin
                            done_d    = 1'b1;
                            frm_cnt_d = '0;
                        end else begin
                            frm_cnt_d = cnt_inc;
                        end
                    end
                    default: beat_d = BT_SCL;
                endcase
            end
        end

        scl_val_d = scl_ld | (scl_val_q & ~o_scl_if.rdy);
        scl_dat_d = scl_ld ? i_pnt_scl_if.dat : scl_dat_q;
        pnt_val_d = pnt_ld | (pnt_val_q & ~o_pnt_if.rdy);
        pnt_sop_d = pnt_ld ? pnt_ld_sop : pnt_sop_q;
        pnt_eop_d = pnt_ld ? ~pnt_ld_sop : pnt_eop_q;
        pnt_dat_d = pnt_ld ? {i_pnt_scl_if.dat, lo_q} : pnt_dat_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_q    <= BT_SCL;
            lo_q      <= '0;
            scl_val_q <= 1'b0;
            scl_dat_q <= '0;
            pnt_val_q <= 1'b0;
            pnt_sop_q <= 1'b0;
            pnt_eop_q <= 1'b0;
            pnt_dat_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            frm_cnt_q <= '0;
        end else begin
            beat_q    <= beat_d;
            lo_q      <= lo_d;
            scl_val_q <= scl_val_d;
            scl_dat_q <= scl_dat_d;
            pnt_val_q <= pnt_val_d;
            pnt_sop_q <= pnt_sop_d;
            pnt_eop_q <= pnt_eop_d;
            pnt_dat_q <= pnt_dat_d;
            err_q     <= err_d;
            done_q    <= done_d;
            frm_cnt_q <= frm_cnt_d;
        end
    end

    assign o_scl_if.val = scl_val_q;
    assign o_scl_if.sop = scl_val_q;
    assign o_scl_if.eop = scl_val_q;
    assign o_scl_if.dat = scl_dat_q;
    assign o_scl_if.ctl = '0;

    assign o_pnt_if.val = pnt_val_q;
    assign o_pnt_if.sop = pnt_sop_q;
    assign o_pnt_if.eop = pnt_eop_q;
    assign o_pnt_if.dat = pnt_dat_q;
    assign o_pnt_if.ctl = '0;

    assign o_err     = err_q;
    assign o_done    = done_q;
    assign o_frm_cnt = frm_cnt_q;

endmodule
